// File: rtl/integer_writeback_pkg.sv
// Shared types for the integer writeback buffer: ROB index, register data,
// address, and the buffered result entry. Also holds the saturating
// increment used by the stall counter.
package integer_writeback_pkg;

  localparam int ROB_ID_W = 6;
  localparam int XLEN     = 32;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [XLEN-1:0]     reg_data_t;
  typedef logic [XLEN-1:0]     addr_t;

  // One execute result as it travels to ROB writeback / broadcast.
  typedef struct packed {
    rob_id_t   rob_id;
    logic      dst_valid;
    reg_data_t dst;
    logic      npc_wb_valid;
    logic      npc_mispred;
    addr_t     npc;
  } int_wb_entry_t;

  localparam int INT_WB_ENTRY_W = $bits(int_wb_entry_t);

  // Add one, but stick at the all-ones value instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/integer_writeback_sync_fifo.sv
// Generic synchronous FIFO with flush. Head data comes straight from the
// storage array addressed by the registered read pointer, so there is no
// flow-through from push to pop and no path from pop_ready to push_ready.
//
// Handshake: a push happens on an edge where push_valid && push_ready; a pop
// happens on an edge where pop_valid && pop_ready. push_ready and pop_valid
// depend only on registered state. Flush and reset both empty the FIFO and
// override any push or pop on the same edge; reset has the higher priority.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (count < CNT_W'(DEPTH));
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is intentionally left unreset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/integer_writeback.sv
// Integer writeback buffer: decouples execute results from the ROB
// writeback / broadcast bus through a small FIFO, and counts the cycles in
// which the head result is offered but not taken.
module integer_writeback
  import integer_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  rob_id_t     ex_rob_id,
  input  logic        ex_dst_valid,
  input  reg_data_t   ex_dst,
  input  logic        ex_npc_wb_valid,
  input  logic        ex_npc_mispred,
  input  addr_t       ex_npc,
  output logic        wb_valid,
  input  logic        wb_ready,
  output rob_id_t     wb_rob_id,
  output logic        wb_dst_valid,
  output reg_data_t   wb_dst,
  output logic        wb_npc_wb_valid,
  output logic        wb_npc_mispred,
  output addr_t       wb_npc,
  output logic [31:0] stall_cycles
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  int_wb_entry_t    in_entry;
  int_wb_entry_t    head_entry;
  logic [CNT_W-1:0] fifo_count;

  assign in_entry = '{
    rob_id:       ex_rob_id,
    dst_valid:    ex_dst_valid,
    dst:          ex_dst,
    npc_wb_valid: ex_npc_wb_valid,
    npc_mispred:  ex_npc_mispred,
    npc:          ex_npc
  };

  sync_fifo #(
    .WIDTH (INT_WB_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (ex_valid),
    .push_ready (ex_ready),
    .push_data  (in_entry),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   (head_entry),
    .count      (fifo_count)
  );

  assign wb_rob_id       = head_entry.rob_id;
  assign wb_dst_valid    = head_entry.dst_valid;
  assign wb_dst          = head_entry.dst;
  assign wb_npc_wb_valid = head_entry.npc_wb_valid;
  assign wb_npc_mispred  = head_entry.npc_mispred;
  assign wb_npc          = head_entry.npc;

  // Saturating count of back-pressured cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (wb_valid && !wb_ready) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
